// File: rtl/acq_ctrl.sv
// acq_ctrl: acquisition sequencer filling a circular capture RAM around a trigger point
module acq_ctrl #(
  parameter int ADDR_W = 8,
  parameter int PRE_DEPTH = 64,
  parameter int HOLDOFF = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_en,
  input  logic              trigger,
  output logic              rst_trig,
  input  logic              run,
  input  logic              single,
  input  logic              disp_done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              frame_rdy,
  output logic              busy
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] PRE_C = (ADDR_W+1)'(PRE_DEPTH);
  localparam logic [ADDR_W:0] POST_C = (ADDR_W+1)'(DEPTH - PRE_DEPTH);
  localparam logic [ADDR_W:0] HOLD_C = (ADDR_W+1)'(HOLDOFF - 1);
  typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, READY, HOLD} state_t;
  state_t state, state_n;
  logic [ADDR_W:0] cnt, cnt_n, cnt_inc;
  logic [ADDR_W-1:0] trig_n;
  logic single_lat, lat_n, abort;
  assign cnt_inc = cnt + (ADDR_W+1)'(1);
  assign wr_en = sample_en && (state == PRE || state == ARMED || state == POST);
  assign rst_trig = !(state == ARMED || state == POST);
  assign busy = state != IDLE;
  assign abort = !run && !single_lat;
  // next-state decode; abort outranks trigger, and a trigger-cycle strobe is post sample 0
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    trig_n = trig_addr;
    lat_n = single_lat;
    case (state)
      IDLE: begin
        lat_n = single && !run;
        if (run || single) begin
          state_n = PRE;
          cnt_n = '0;
        end
      end
      PRE:
        if (abort) state_n = IDLE;
        else if (sample_en) begin
          cnt_n = cnt_inc;
          state_n = cnt_inc == PRE_C ? ARMED : PRE;
        end
      ARMED:
        if (abort) state_n = IDLE;
        else if (trigger) begin
          trig_n = wr_addr;
          cnt_n = {{ADDR_W{1'b0}}, sample_en};
          state_n = POST;
        end
      POST:
        if (sample_en) begin
          cnt_n = cnt_inc;
          state_n = cnt_inc == POST_C ? READY : POST;
        end
      READY:
        if (disp_done) begin
          state_n = HOLD;
          cnt_n = '0;
        end
      HOLD:
        if (cnt == HOLD_C) begin
          state_n = run ? PRE : IDLE;
          cnt_n = '0;
          lat_n = run && single_lat;
        end else cnt_n = cnt_inc;
      default: state_n = IDLE;
    endcase
  end
  // state and datapath registers; write address advances on every accepted write
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      wr_addr <= '0;
      trig_addr <= '0;
      single_lat <= 1'b0;
      frame_rdy <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      wr_addr <= wr_en ? wr_addr + ADDR_W'(1) : wr_addr;
      trig_addr <= trig_n;
      single_lat <= lat_n;
      frame_rdy <= state_n == READY;
    end
  end
endmodule

// File: tb/tb_acq_ctrl.sv
// tb_acq_ctrl: directed checks of the acquisition sequencer with default parameters
module tb_acq_ctrl;
  logic clk = 0, rst = 1, sample_en = 0, trigger = 0, run = 0, single = 0, disp_done = 0;
  logic rst_trig, wr_en, frame_rdy, busy;
  logic [7:0] wr_addr, trig_addr;
  int n_cmp = 0, n_err = 0, wr_cnt = 0, ph = 0, w0 = 0;
  bit se_mode = 0;

  acq_ctrl dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .trigger(trigger), .rst_trig(rst_trig),
    .run(run), .single(single), .disp_done(disp_done), .wr_en(wr_en), .wr_addr(wr_addr),
    .trig_addr(trig_addr), .frame_rdy(frame_rdy), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (wr_en) wr_cnt <= wr_cnt + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (se_mode) begin
        ph++;
        sample_en = (ph % 4 == 0);
      end
    end
  endtask

  task automatic wait_armed(input string tag, input int max);
    int n = 0;
    while (rst_trig !== 1'b0 && n < max) begin
      step(1);
      n++;
    end
    chk(tag, int'(rst_trig), 0);
  endtask

  task automatic wait_rdy(input string tag, input int max);
    int n = 0;
    while (frame_rdy !== 1'b1 && n < max) begin
      step(1);
      n++;
    end
    chk(tag, int'(frame_rdy), 1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_wr_addr"}, int'(wr_addr), 0);
    chk({tag, "_trig_addr"}, int'(trig_addr), 0);
    chk({tag, "_frame_rdy"}, int'(frame_rdy), 0);
    chk({tag, "_wr_en"}, int'(wr_en), 0);
    chk({tag, "_rst_trig"}, int'(rst_trig), 1);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    // reset held with run high
    rst = 1; run = 1; sample_en = 1;
    step(2);
    chk_reset("rst");
    rst = 0;
    step(1);
    chk("pre_after_rst", int'(busy), 1);
    run = 0;
    step(1);
    chk("abort_pre", int'(busy), 0);
    rst = 1; step(1); rst = 0;

    // single shot, strobe every cycle, trigger 10 cycles into ARMED
    single = 1;
    step(1);
    single = 0;
    chk("single_busy", int'(busy), 1);
    w0 = wr_cnt;
    step(63);
    chk("pre63_rst_trig", int'(rst_trig), 1);
    step(1);
    chk("armed_rst_trig", int'(rst_trig), 0);
    chk("armed_writes", wr_cnt - w0, 64);
    chk("armed_wr_addr", int'(wr_addr), 64);
    disp_done = 1;
    step(10);
    disp_done = 0;
    chk("disp_in_armed", int'(rst_trig), 0);
    chk("armed10_wr_addr", int'(wr_addr), 74);
    trigger = 1;
    step(1);
    chk("ss_trig_addr", int'(trig_addr), 74);
    chk("post_rst_trig", int'(rst_trig), 0);
    single = 1;
    step(1);
    single = 0;
    wait_rdy("ss_rdy_timeout", 300);
    chk("ss_wr_addr_wrap", int'(wr_addr), 10);
    chk("ss_total_writes", wr_cnt - w0, 266);
    chk("ss_trig_addr_hold", int'(trig_addr), 74);
    trigger = 0;
    step(5);
    chk("ready_no_writes", wr_cnt - w0, 266);
    chk("ready_wr_en", int'(wr_en), 0);
    chk("ready_frame_rdy", int'(frame_rdy), 1);
    disp_done = 1;
    step(1);
    disp_done = 0;
    chk("hold_frame_rdy", int'(frame_rdy), 0);
    chk("hold_busy", int'(busy), 1);
    step(14);
    chk("hold_wr_en", int'(wr_en), 0);
    step(1);
    chk("hold_last_busy", int'(busy), 1);
    chk("hold_wr_addr", int'(wr_addr), 10);
    step(1);
    chk("ss_idle", int'(busy), 0);

    // trigger high through pre-fill
    rst = 1; step(1); rst = 0;
    trigger = 1; single = 1;
    step(1);
    single = 0;
    step(63);
    chk("tpre_rst_trig", int'(rst_trig), 1);
    step(1);
    chk("tpre_armed", int'(rst_trig), 0);
    step(1);
    chk("tpre_trig_addr", int'(trig_addr), 64);
    chk("tpre_post", int'(rst_trig), 0);
    step(5);
    rst = 1;
    step(1);
    chk_reset("midpost");
    rst = 0; trigger = 0;

    // continuous run, strobe every 4th cycle
    se_mode = 1; ph = 0; sample_en = 0; run = 1;
    step(1);
    w0 = wr_cnt;
    wait_armed("c1_armed_timeout", 1000);
    chk("c1_pre_writes", wr_cnt - w0, 64);
    chk("c1_wr_addr", int'(wr_addr), 64);
    trigger = 1;
    w0 = wr_cnt;
    step(1);
    trigger = 0;
    chk("c1_trig_addr", int'(trig_addr), 64);
    wait_rdy("c1_rdy_timeout", 1000);
    chk("c1_post_writes", wr_cnt - w0, 192);
    chk("c1_wr_addr_end", int'(wr_addr), 0);
    disp_done = 1; se_mode = 0; sample_en = 1;
    step(1);
    disp_done = 0;
    w0 = wr_cnt;
    step(15);
    chk("c_hold_last_wr_en", int'(wr_en), 0);
    chk("c_hold_writes", wr_cnt - w0, 0);
    step(1);
    chk("c_repre_wr_en", int'(wr_en), 1);
    chk("c_repre_rst_trig", int'(rst_trig), 1);
    w0 = wr_cnt;
    se_mode = 1;
    wait_armed("c2_armed_timeout", 1000);
    chk("c2_pre_writes", wr_cnt - w0, 64);
    trigger = 1;
    w0 = wr_cnt;
    step(1);
    trigger = 0;
    wait_rdy("c2_rdy_timeout", 1000);
    chk("c2_post_writes", wr_cnt - w0, 192);
    run = 0; disp_done = 1;
    step(1);
    disp_done = 0;
    step(16);
    chk("c_idle", int'(busy), 0);
    se_mode = 0;

    // abort in ARMED beats a simultaneous trigger; run drop in POST completes the frame
    rst = 1; step(1); rst = 0;
    sample_en = 1; run = 1;
    step(1);
    wait_armed("ab_armed_timeout", 200);
    run = 0; trigger = 1;
    step(1);
    chk("ab_busy", int'(busy), 0);
    chk("ab_frame_rdy", int'(frame_rdy), 0);
    trigger = 0; run = 1;
    step(1);
    wait_armed("pd_armed_timeout", 200);
    trigger = 1;
    w0 = wr_cnt;
    step(5);
    run = 0; trigger = 0;
    chk("pd_post5", wr_cnt - w0, 5);
    wait_rdy("pd_rdy_timeout", 300);
    chk("pd_post_writes", wr_cnt - w0, 192);
    disp_done = 1;
    step(1);
    disp_done = 0;
    step(16);
    chk("pd_idle", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/acq_ctrl.md
Name: acq_ctrl

Overview:
- Acquisition sequencer for the scope front end.
- Arms and clears the trigger controller, and writes incoming samples into a circular capture RAM.
- Captures a fixed pre-trigger/post-trigger window, then hands the frame to the display reader.
- Runs continuous (auto-rearm) or single-shot, with a holdoff between frames.

Parameters:
ADDR_W, 8, capture RAM address width; DEPTH = 2^ADDR_W samples per frame
PRE_DEPTH, 64, samples kept before the trigger point (1 .. DEPTH-1)
HOLDOFF, 16, clock cycles idle after a frame is consumed before re-arming (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
sample_en  in  1  one-cycle strobe: new sample valid this cycle
trigger  in  1  sticky trigger flag from the trigger controller
rst_trig  out  1  clears the trigger controller while high
run  in  1  level: continuous acquisition
single  in  1  pulse: arm one acquisition
disp_done  in  1  pulse: display finished reading the frame
wr_en  out  1  capture RAM write enable
wr_addr  out  ADDR_W  capture RAM write address
trig_addr  out  ADDR_W  RAM address of the first sample at/after the trigger
frame_rdy  out  1  complete frame in RAM
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, PRE, ARMED, POST, READY, HOLD. State, counters, wr_addr, trig_addr and frame_rdy are registers.
- wr_en is a combinational decode: wr_en = sample_en AND state in {PRE, ARMED, POST}.
- Sample data is written in the same cycle as its strobe at the current wr_addr. wr_addr increments on that edge, modulo DEPTH, with silent wrap.
- rst_trig = 1 in IDLE, PRE, READY and HOLD; 0 in ARMED and POST. Trigger events during pre-fill are therefore discarded.
- Reset, synchronous, takes priority over everything, including mid-frame:
  - state IDLE; wr_addr 0; trig_addr 0; cnt 0; single_lat 0.
  - frame_rdy 0; wr_en 0; rst_trig 1; busy 0.
- IDLE:
  - run=1 or single=1 -> PRE; cnt cleared.
  - single_lat <= single AND NOT run.
- PRE:
  - Each strobe writes and increments cnt.
  - When the write that makes cnt == PRE_DEPTH occurs -> ARMED on the same edge.
- ARMED:
  - Strobes keep writing in circular fashion.
  - When trigger=1 is sampled: trig_addr <= current wr_addr; cnt <= 0; -> POST.
  - A strobe in the same cycle is written at trig_addr and counts as post sample 0, so cnt <= 1 in that case.
- POST:
  - Strobes write and count.
  - When the write making cnt == DEPTH - PRE_DEPTH occurs -> READY.
  - Frame start address = trig_addr - PRE_DEPTH mod DEPTH.
  - trigger is ignored in POST.
- READY:
  - frame_rdy = 1; no writes; trig_addr and wr_addr frozen.
  - disp_done -> HOLD; frame_rdy drops on that edge.
- HOLD:
  - Count HOLDOFF clock cycles; sample_en is ignored.
  - At expiry: run=1 -> PRE (cnt cleared, full pre-fill repeated). Otherwise -> IDLE; single_lat cleared.
- Abort: in PRE or ARMED, run=0 and single_lat=0 -> IDLE next edge; no frame.
- Once in POST the frame always completes, whatever run does.
- Ignored inputs: single while busy; disp_done outside READY; trigger outside ARMED.
- Simultaneous events:
  - rst beats all.
  - Trigger with run falling in ARMED: abort wins.
  - A strobe on the final PRE write and entry to ARMED: the trigger is evaluated from the next cycle.
- Counters are ADDR_W+1 bits wide; no overflow is possible.

Test Plan:
(defaults: DEPTH 256, PRE_DEPTH 64, HOLDOFF 16)
- Reset: hold rst 2 cycles with run=1 -> wr_addr=0, trig_addr=0, frame_rdy=0, wr_en=0, rst_trig=1, busy=0. PRE is entered only on the first cycle after rst drops.
- Single shot, sample_en every cycle, trigger raised 10 cycles after ARMED -> ARMED after exactly 64 writes; trig_addr=74; 192 post writes; frame_rdy=1 with wr_addr=10 (wrapped); no further writes; disp_done -> HOLD 16 cycles -> IDLE, busy=0.
- trigger held high throughout PRE -> rst_trig stays 1 and no early trigger is taken. rst_trig falls on ARMED entry, and the first ARMED-cycle trigger gives trig_addr=64.
- Continuous run, strobe every 4th cycle -> only strobes advance wr_addr/cnt; after disp_done, exactly 16 HOLD cycles, then PRE with rst_trig=1 and cnt=0; second frame completes.
- run dropped in ARMED -> IDLE next edge, frame_rdy never set. run dropped after 5 POST writes -> the remaining 187 writes complete, then frame_rdy=1.
- rst asserted mid-POST -> next edge gives all reset values. single during POST and disp_done during ARMED -> no effect.
